// File: rtl/fact_arbiter_if.sv
// Requester handshakes, shared response bus and accelerator bus of fact_arbiter.
// The master modport is the arbiter's view; slave is the clients plus the accelerator.
interface fact_arbiter_if;
  logic        req0_valid;
  logic [3:0]  req0_n;
  logic        req0_ready;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        req1_valid;
  logic [3:0]  req1_n;
  logic        req1_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [1:0]  fa_A;
  logic        fa_WE;
  logic [3:0]  fa_WD;
  logic [31:0] fa_RD;
  logic        busy;
  logic        owner;

  modport master (
    input  req0_valid, req0_n, rsp0_ready, req1_valid, req1_n, rsp1_ready, fa_RD,
    output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
    output rsp_result, rsp_err, rsp_timeout, fa_A, fa_WE, fa_WD, busy, owner
  );

  modport slave (
    output req0_valid, req0_n, rsp0_ready, req1_valid, req1_n, rsp1_ready, fa_RD,
    input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
    input  rsp_result, rsp_err, rsp_timeout, fa_A, fa_WE, fa_WD, busy, owner
  );
endinterface

// File: rtl/fact_arbiter.sv
// Two-requester round-robin arbiter that sequences one factorial accelerator:
// write n, pulse Go, poll status, read result, then answer the owning requester.
module fact_arbiter #(
  parameter int POLL_TIMEOUT = 255,
  parameter int CNT_W        = 8
) (
  input  logic          clk,
  input  logic          Rst,
  fact_arbiter_if.master bus
);
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_N   = 3'd1,
    ST_WR_GO  = 3'd2,
    ST_POLL   = 3'd3,
    ST_RD_RES = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  state_t             state_r;
  logic               rr_r;
  logic               owner_r;
  logic               busy_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         fa_a_r;
  logic               fa_we_r;
  logic [3:0]         fa_wd_r;
  logic               rsp0_valid_r;
  logic               rsp1_valid_r;
  logic [31:0]        rsp_result_r;
  logic               rsp_err_r;
  logic               rsp_timeout_r;

  logic               sel_s;
  logic               grant_s;
  logic [3:0]         sel_n_s;
  logic               rsp_ready_s;

  // Requester selection; the round-robin pointer only matters when both ask.
  always_comb begin
    sel_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      sel_s = rr_r;
    end else if (bus.req1_valid) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  assign grant_s        = (state_r == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
  assign sel_n_s        = sel_s ? bus.req1_n : bus.req0_n;
  assign rsp_ready_s    = owner_r ? bus.rsp1_ready : bus.rsp0_ready;
  assign bus.req0_ready = grant_s && !sel_s;
  assign bus.req1_ready = grant_s && sel_s;

  // Sequencer: every bus and response output is registered alongside the state.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_r       <= ST_IDLE;
      rr_r          <= 1'b0;
      owner_r       <= 1'b0;
      busy_r        <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
      fa_a_r        <= 2'd0;
      fa_we_r       <= 1'b0;
      fa_wd_r       <= 4'd0;
      rsp0_valid_r  <= 1'b0;
      rsp1_valid_r  <= 1'b0;
      rsp_result_r  <= 32'd0;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            owner_r <= sel_s;
            busy_r  <= 1'b1;
            fa_a_r  <= 2'd0;
            fa_we_r <= 1'b1;
            fa_wd_r <= sel_n_s;
            state_r <= ST_WR_N;
          end
        end
        ST_WR_N: begin
          fa_a_r  <= 2'd1;
          fa_wd_r <= 4'b0001;
          state_r <= ST_WR_GO;
        end
        ST_WR_GO: begin
          fa_a_r  <= 2'd2;
          fa_we_r <= 1'b0;
          fa_wd_r <= 4'd0;
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= ST_POLL;
        end
        ST_POLL: begin
          // Error outranks done; timeout only when neither bit is set.
          if (bus.fa_RD[1]) begin
            rsp_result_r  <= 32'd0;
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b0;
            fa_a_r        <= 2'd0;
            rsp0_valid_r  <= !owner_r;
            rsp1_valid_r  <= owner_r;
            state_r       <= ST_RESP;
          end else if (bus.fa_RD[0]) begin
            fa_a_r  <= 2'd3;
            state_r <= ST_RD_RES;
          end else if (cnt_r == CNT_W'(POLL_TIMEOUT - 1)) begin
            rsp_result_r  <= 32'd0;
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b1;
            fa_a_r        <= 2'd0;
            rsp0_valid_r  <= !owner_r;
            rsp1_valid_r  <= owner_r;
            state_r       <= ST_RESP;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RD_RES: begin
          rsp_result_r  <= bus.fa_RD;
          rsp_err_r     <= 1'b0;
          rsp_timeout_r <= 1'b0;
          fa_a_r        <= 2'd0;
          rsp0_valid_r  <= !owner_r;
          rsp1_valid_r  <= owner_r;
          state_r       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_s) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rr_r         <= !owner_r;
            busy_r       <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
          fa_a_r       <= 2'd0;
          fa_we_r      <= 1'b0;
          fa_wd_r      <= 4'd0;
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fa_A        = fa_a_r;
  assign bus.fa_WE       = fa_we_r;
  assign bus.fa_WD       = fa_wd_r;
  assign bus.rsp0_valid  = rsp0_valid_r;
  assign bus.rsp1_valid  = rsp1_valid_r;
  assign bus.rsp_result  = rsp_result_r;
  assign bus.rsp_err     = rsp_err_r;
  assign bus.rsp_timeout = rsp_timeout_r;
  assign bus.busy        = busy_r;
  assign bus.owner       = owner_r;
endmodule

// File: tb/tb_fact_arbiter.sv
// Directed bench for fact_arbiter with a small behavioural accelerator on the fa bus.
module tb_fact_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fact_arbiter_if bus ();

  fact_arbiter #(.POLL_TIMEOUT(8), .CNT_W(8)) dut (
    .clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Accelerator stand-in: done (or overflow err) 3 edges after Go; hang stalls it.
  bit          hang   = 1'b0;
  logic [3:0]  m_n    = 4'd0;
  logic        m_done = 1'b0;
  logic        m_err  = 1'b0;
  logic        m_busy = 1'b0;
  logic [1:0]  m_cd   = 2'd0;
  logic [31:0] m_res  = 32'd0;

  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.fa_WE && bus.fa_A == 2'd0) m_n <= bus.fa_WD;
    if (bus.fa_WE && bus.fa_A == 2'd1) begin
      m_busy <= 1'b1; m_done <= 1'b0; m_err <= 1'b0; m_cd <= 2'd2;
    end else if (m_busy && !hang) begin
      if (m_cd == 2'd0) begin
        m_busy <= 1'b0;
        if (m_n > 4'd12) m_err <= 1'b1;
        else begin m_done <= 1'b1; m_res <= fact(m_n); end
      end else m_cd <= m_cd - 2'd1;
    end
  end

  always_comb begin
    case (bus.fa_A)
      2'd0:    bus.fa_RD = {28'd0, m_n};
      2'd1:    bus.fa_RD = 32'd0;
      2'd2:    bus.fa_RD = {30'd0, m_err, m_done};
      default: bus.fa_RD = m_res;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic accept(input bit who, input logic [3:0] n);
    bit ok = 1'b0;
    if (who) begin bus.req1_valid = 1'b1; bus.req1_n = n; end
    else     begin bus.req0_valid = 1'b1; bus.req0_n = n; end
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if ((who ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        @(posedge clk); #1; ok = 1'b1;
      end
    end
    if (who) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL accept_wait: got no ready expected ready for req%0d", who); end
  endtask

  // Leaves the caller on the negedge where a response is first visible.
  task automatic wait_rsp(output int polls);
    bit ok = 1'b0;
    polls = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (bus.rsp0_valid === 1'b1 || bus.rsp1_valid === 1'b1) ok = 1'b1;
      else if (bus.fa_A == 2'd2 && bus.busy) polls++;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rsp_wait: got no rsp_valid expected rsp_valid"); end
  endtask

  task automatic respond(input bit who);
    if (who) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  typedef struct {
    bit          who;
    logic [3:0]  n;
    bit          hang;
    logic [31:0] res;
    bit          err;
    bit          to;
    int          polls;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int polls;
    tbl[0] = '{1'b0, 4'd5,  1'b0, 32'd120,       1'b0, 1'b0, 4};
    tbl[1] = '{1'b1, 4'd4,  1'b0, 32'd24,        1'b0, 1'b0, 4};
    tbl[2] = '{1'b0, 4'd13, 1'b0, 32'd0,         1'b1, 1'b0, 4};
    tbl[3] = '{1'b1, 4'd0,  1'b0, 32'd1,         1'b0, 1'b0, 4};
    tbl[4] = '{1'b0, 4'd12, 1'b0, 32'd479001600, 1'b0, 1'b0, 4};
    tbl[5] = '{1'b1, 4'd9,  1'b1, 32'd0,         1'b1, 1'b1, 8};
    tbl[6] = '{1'b0, 4'd7,  1'b0, 32'd5040,      1'b0, 1'b0, 4};

    bus.req0_valid = 1'b0; bus.req0_n = 4'd0; bus.rsp0_ready = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_n = 4'd0; bus.rsp1_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fa", 32'({bus.fa_A, bus.fa_WE, bus.fa_WD}), 32'd0);
    chk("rst_rsp", 32'({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.rsp_timeout}), 32'd0);
    chk("rst_result", bus.rsp_result, 32'd0);
    chk("rst_busy_owner", 32'({bus.busy, bus.owner}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Both valid in the same cycle after reset: req0 first, then req1
    bus.req0_valid = 1'b1; bus.req0_n = 4'd3;
    bus.req1_valid = 1'b1; bus.req1_n = 4'd4;
    @(negedge clk);
    chk("both_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'b01);
    @(posedge clk); #1; bus.req0_valid = 1'b0;
    wait_rsp(polls);
    chk("both_first_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'b01);
    chk("both_first_result", bus.rsp_result, 32'd6);
    respond(1'b0);
    accept(1'b1, 4'd4);
    wait_rsp(polls);
    chk("both_second_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'b10);
    chk("both_second_result", bus.rsp_result, 32'd24);
    respond(1'b1);

    // Bus writes and sequencing for a single job
    accept(1'b0, 4'd5);
    chk("wr_n_bus", 32'({bus.fa_A, bus.fa_WE, bus.fa_WD}), 32'({2'd0, 1'b1, 4'd5}));
    @(posedge clk); #1;
    chk("wr_go_bus", 32'({bus.fa_A, bus.fa_WE, bus.fa_WD}), 32'({2'd1, 1'b1, 4'd1}));
    @(posedge clk); #1;
    chk("poll_bus", 32'({bus.fa_A, bus.fa_WE, bus.fa_WD}), 32'({2'd2, 1'b0, 4'd0}));
    wait_rsp(polls);
    chk("seq_result", bus.rsp_result, 32'd120);
    chk("seq_err", 32'(bus.rsp_err), 32'd0);
    respond(1'b0);

    // Table of single-requester jobs
    for (int k = 0; k < 7; k++) begin
      hang = tbl[k].hang;
      accept(tbl[k].who, tbl[k].n);
      wait_rsp(polls);
      chk($sformatf("v%0d_valid", k), 32'({bus.rsp1_valid, bus.rsp0_valid}), tbl[k].who ? 32'b10 : 32'b01);
      chk($sformatf("v%0d_owner", k), 32'(bus.owner), 32'(tbl[k].who));
      chk($sformatf("v%0d_result", k), bus.rsp_result, tbl[k].res);
      chk($sformatf("v%0d_err", k), 32'(bus.rsp_err), 32'(tbl[k].err));
      chk($sformatf("v%0d_timeout", k), 32'(bus.rsp_timeout), 32'(tbl[k].to));
      chk($sformatf("v%0d_polls", k), 32'(polls), 32'(tbl[k].polls));
      respond(tbl[k].who);
      hang = 1'b0;
      chk($sformatf("v%0d_idle", k), 32'(bus.busy), 32'd0);
    end

    // Both held valid for four jobs: last served was req0, so grants run 1,0,1,0
    bus.req0_valid = 1'b1; bus.req0_n = 4'd1;
    bus.req1_valid = 1'b1; bus.req1_n = 4'd2;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(polls);
      chk($sformatf("alt%0d_valid", k), 32'({bus.rsp1_valid, bus.rsp0_valid}), (k % 2 == 0) ? 32'b10 : 32'b01);
      chk($sformatf("alt%0d_result", k), bus.rsp_result, (k % 2 == 0) ? 32'd2 : 32'd1);
      respond((k % 2) == 0);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    // Response back-pressure: result held, other requester locked out
    accept(1'b0, 4'd6);
    wait_rsp(polls);
    bus.req1_valid = 1'b1; bus.req1_n = 4'd2;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_result", k), bus.rsp_result, 32'd720);
      chk($sformatf("stall%0d_hs", k), 32'({bus.rsp0_valid, bus.req1_ready}), 32'b10);
      @(negedge clk);
    end
    respond(1'b0);
    accept(1'b1, 4'd2);
    wait_rsp(polls);
    chk("after_stall_result", bus.rsp_result, 32'd2);
    respond(1'b1);

    // Reset in the middle of polling, then a clean job
    bus.req0_valid = 1'b1; bus.req0_n = 4'd9;
    accept(1'b0, 4'd9);
    for (int i = 0; i < 20 && bus.fa_A != 2'd2; i++) @(negedge clk);
    chk("midpoll_reached", 32'(bus.fa_A), 32'd2);
    rst_n = 1'b0; #1;
    chk("midrst_fa", 32'({bus.fa_A, bus.fa_WE, bus.fa_WD}), 32'd0);
    chk("midrst_rsp", 32'({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.rsp_timeout, bus.busy, bus.owner}), 32'd0);
    chk("midrst_result", bus.rsp_result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    accept(1'b0, 4'd4);
    wait_rsp(polls);
    chk("post_rst_result", bus.rsp_result, 32'd24);
    chk("post_rst_err", 32'(bus.rsp_err), 32'd0);
    respond(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
